uart_tx_fsm: RTL

- Frame controller for the UART transmit path.
- Accepts a parallel word plus parity configuration, then sequences start bit, data phase, optional parity bit and stop bit onto the serial line.
- Drives the serializer's shift enable and consumes its serial bit and done flag.
- Sits between the register/FIFO front end (Data_Valid/P_DATA) and the TX pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fsm_parity_calc.sv | 21 ++
 rtl/uart_tx_fsm.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit frame controller.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } tx_state_t;

  // A new frame may only be accepted from these states.
  function automatic logic can_accept(input tx_state_t s);
    return (s == ST_IDLE) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// Combinational parity of a data word; even or odd selected by PAR_TYP.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] data,
  input  logic                 PAR_TYP,
  output logic                 parity
);

  always_comb begin
    parity = ^data;
    case (PAR_TYP)
      PAR_EVEN: parity = ^data;
      PAR_ODD:  parity = ~^data;
      default:  parity = ^data;
    endcase
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, data (from serializer), optional parity, stop.
// Outputs are decoded combinationally from state, captured config and ser_data.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int TOWIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Data_Valid,
  input  logic [DATAWIDTH-1:0] P_DATA,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  input  logic                 ser_data,
  input  logic                 ser_done,
  output logic                 ser_en,
  output logic                 TX_OUT,
  output logic                 Busy,
  output logic                 Tx_Err
);

  localparam logic [TOWIDTH-1:0] TIMEOUT = TOWIDTH'(DATAWIDTH + 1);

  tx_state_t          state_q, state_d;
  logic               par_bit_q, par_bit_d;
  logic               par_en_q, par_en_d;
  logic               err_q, err_d;
  logic [TOWIDTH-1:0] cnt_q, cnt_d;
  logic [TOWIDTH-1:0] cnt_inc;
  logic               par_calc;
  logic               accept;

  parity_calc #(
    .DATAWIDTH(DATAWIDTH)
  ) u_parity (
    .data   (P_DATA),
    .PAR_TYP(PAR_TYP),
    .parity (par_calc)
  );

  assign cnt_inc = cnt_q + TOWIDTH'(1);
  assign accept  = Data_Valid && can_accept(state_q);
  assign Tx_Err  = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    TX_OUT    = 1'b1;
    Busy      = 1'b0;
    ser_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_START: begin
        TX_OUT  = 1'b0;
        Busy    = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        TX_OUT = ser_data;
        Busy   = 1'b1;
        ser_en = 1'b1;
        cnt_d  = cnt_inc;
        // A done on the timeout edge is a normal completion.
        if (ser_done) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else if (cnt_inc == TIMEOUT) begin
          state_d = ST_STOP;
          err_d   = 1'b1;
        end
      end
      ST_PARITY: begin
        TX_OUT  = par_bit_q;
        Busy    = 1'b1;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        Busy    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Acceptance in STOP chains straight into the next start bit.
    if (accept) begin
      state_d   = ST_START;
      par_bit_d = par_calc;
      par_en_d  = PAR_EN;
      err_d     = 1'b0;
      cnt_d     = '0;
    end
  end

endmodule
